rx_crc5_engine: RTL and testbench
=================================

# rx_crc5_engine

Receive-side CRC5 engine for the HDR-DDR path. It consumes each deserialized data byte as the RX deserializer completes it and folds it into a running CRC5, MSB first, using polynomial x^5+x^2+1 with seed 5'b11111. When RX enters its CRC check phase, the engine presents the final 5-bit CRC with a valid flag for comparison against the received CRC word. The DDR CCC controller re-seeds the engine at the start of every data phase.

## Interface
Parameters:
- SEED, 5'b11111, CRC value loaded on reset and on init.
- POLY, 5'b00101, low-order feedback taps of x^5+x^2+1.

Ports:
- i_sys_clk  input  1  system clock; the only clock in the block.
- i_sys_rst  input  1  asynchronous, active-low reset.
- i_ddrccc_crc_init  input  1  synchronous re-seed pulse from the DDR CCC controller.
- i_rx_byte_valid  input  1  one-cycle pulse; i_rx_byte is complete on this cycle.
- i_rx_byte  input  8  deserialized data byte, MSB first on the wire.
- i_rx_crc_en  input  1  level from RX, high while RX is in its CRC check mode.
- o_rx_crc_value  output  5  final CRC; meaningful only while o_rx_crc_valid is high.
- o_rx_crc_valid  output  1  CRC final and stable.
- o_crc_busy  output  1  shifting is in progress or the holding buffer is occupied.
- o_ddrccc_crc_error  output  1  sticky protocol error: overrun, or a byte arrived in DONE.

## Operation
- Internal state:
  - crc[4:0]
  - shift register sh[7:0]
  - bit counter cnt[2:0]
  - one-deep holding buffer hb[7:0] with flag hb_full
- FSM states: IDLE, SHIFT, DONE.
- Per-bit update:
  - fb = crc[4] ^ sh[7]
  - crc <= {crc[3:0],1'b0} ^ (fb ? POLY : 5'b0)
  - sh <= sh<<1
  - cnt <= cnt-1
- IDLE:
  - byte_valid: sh <= i_rx_byte, cnt <= 7, go to SHIFT.
  - Otherwise, crc_en with hb_full=0: go to DONE.
- SHIFT: process one bit per clock. On the edge that processes cnt==0:
  - hb_full: load sh from hb, clear hb_full, cnt <= 7, stay in SHIFT.
  - Else byte_valid this cycle: load sh from i_rx_byte, stay in SHIFT.
  - Else: go to IDLE.
- Byte arriving in SHIFT when cnt!=0:
  - hb empty: store in hb, set hb_full.
  - hb already full: drop the byte and set o_ddrccc_crc_error.
- DONE:
  - o_rx_crc_value = crc; o_rx_crc_valid = 1.
  - crc stays frozen.
  - crc_en low: return to IDLE, valid drops.
  - byte_valid in DONE: byte ignored, o_ddrccc_crc_error set.
- i_ddrccc_crc_init overrides all other inputs in its cycle:
  - crc <= SEED, hb_full <= 0, error <= 0, state <= IDLE, valid <= 0.
  - A byte_valid in the same cycle is discarded.
- crc_en asserted while in SHIFT or with hb_full: DONE is deferred until all bytes are folded in. Valid never reflects a partial CRC.

## Timing
- Reset values:
  - o_rx_crc_value = 5'b00000 (output register; internal crc = SEED).
  - o_rx_crc_valid = 0, o_crc_busy = 0, o_ddrccc_crc_error = 0.
  - State = IDLE.
- Byte latency: byte sampled at edge E0; bits processed at E1..E8; crc final after E8.
- Valid latency: with crc_en already high, o_rx_crc_valid rises after E9 (IDLE to DONE edge).
- Back-to-back bytes:
  - A byte at the E8 cycle is accepted with no bubble.
  - Throughput is 1 byte per 8 clocks.
  - RX delivers at most one byte per 8 SCL edges, so hb only absorbs jitter.
- o_crc_busy is combinational: (state==SHIFT) | hb_full.
- o_rx_crc_value and o_rx_crc_valid are registered and change only on the DONE entry and exit edges.
- Asynchronous reset mid-shift: all state clears immediately; no partial CRC is retained.

## Test plan
- Reset, init, then byte 0xFF, then crc_en high -> o_rx_crc_value = 5'b11011, valid asserted 9 clocks after the byte pulse.
- Init, bytes 0x00 and 0x00 spaced 8 clocks apart, then crc_en -> value 5'b00001. After the first byte, the internal crc reads 5'b01111.
- Second byte pulsed 3 clocks after the first -> held in hb. Result is identical to the spaced case (5'b00001); busy stays high for 16 clocks.
- Three byte pulses within 4 clocks -> third byte dropped, o_ddrccc_crc_error = 1. Error clears only on the next init.
- crc_en raised 2 clocks after a byte pulse -> valid withheld until shifting ends. Valid rises with value 5'b11011 for byte 0xFF.
- Init pulsed mid-SHIFT, coincident with byte_valid -> crc = 5'b11111, busy = 0, the byte is discarded. A later 0xFF still yields 5'b11011.

Source files
------------

// File: rtl/rx_crc5_engine.sv
// Receive-side CRC5 engine: folds deserialized bytes MSB first into a running
// x^5+x^2+1 CRC and presents the final value while RX is in its CRC check phase.
module rx_crc5_engine #(
  parameter logic [4:0] SEED = 5'b11111,
  parameter logic [4:0] POLY = 5'b00101
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_ddrccc_crc_init,
  input  logic       i_rx_byte_valid,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_crc_en,
  output logic [4:0] o_rx_crc_value,
  output logic       o_rx_crc_valid,
  output logic       o_crc_busy,
  output logic       o_ddrccc_crc_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic [4:0]  crc_r;
  logic [7:0]  sh_r;
  logic [2:0]  cnt_r;
  logic [7:0]  hb_r;
  logic        hb_full_r;
  logic        err_r;
  logic [4:0]  value_r;
  logic        valid_r;

  logic        shift_s;
  logic        load_byte_s;
  logic        load_hb_s;
  logic        store_hb_s;
  logic        drop_s;
  logic        enter_done_s;
  logic        exit_done_s;
  logic        busy_s;
  logic        last_bit_s;

  // One serial CRC step: shift left, fold in taps when the outgoing bit differs from data.
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
    logic fb;
    fb = crc[4] ^ din;
    return {crc[3:0], 1'b0} ^ (fb ? POLY : 5'b00000);
  endfunction

  assign last_bit_s = (cnt_r == 3'd0);

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; init re-seeds from any state.
  always_comb begin
    state_s = state_r;
    if (i_ddrccc_crc_init) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_rx_byte_valid) begin
            state_s = ST_SHIFT;
          end else if (i_rx_crc_en && !hb_full_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (last_bit_s && !hb_full_r && !i_rx_byte_valid) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (!i_rx_crc_en) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath controls decoded from state and inputs.
  always_comb begin
    shift_s      = 1'b0;
    load_byte_s  = 1'b0;
    load_hb_s    = 1'b0;
    store_hb_s   = 1'b0;
    drop_s       = 1'b0;
    enter_done_s = 1'b0;
    exit_done_s  = 1'b0;
    busy_s       = (state_r == ST_SHIFT) | hb_full_r;
    if (i_ddrccc_crc_init) begin
      shift_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          load_byte_s  = i_rx_byte_valid;
          enter_done_s = !i_rx_byte_valid && i_rx_crc_en && !hb_full_r;
        end
        ST_SHIFT: begin
          shift_s = 1'b1;
          if (last_bit_s) begin
            if (hb_full_r) begin
              // Buffered byte goes in first; a new arrival refills the freed slot.
              load_hb_s  = 1'b1;
              store_hb_s = i_rx_byte_valid;
            end else begin
              load_byte_s = i_rx_byte_valid;
            end
          end else if (i_rx_byte_valid) begin
            if (hb_full_r) begin
              drop_s = 1'b1;
            end else begin
              store_hb_s = 1'b1;
            end
          end else begin
            drop_s = 1'b0;
          end
        end
        ST_DONE: begin
          drop_s      = i_rx_byte_valid;
          exit_done_s = !i_rx_crc_en;
        end
        default: begin
          shift_s = 1'b0;
        end
      endcase
    end
  end

  // CRC, shifter, holding buffer, sticky error and registered result.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      crc_r     <= SEED;
      sh_r      <= 8'h00;
      cnt_r     <= 3'd0;
      hb_r      <= 8'h00;
      hb_full_r <= 1'b0;
      err_r     <= 1'b0;
      value_r   <= 5'b00000;
      valid_r   <= 1'b0;
    end else if (i_ddrccc_crc_init) begin
      crc_r     <= SEED;
      hb_full_r <= 1'b0;
      err_r     <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      if (shift_s) begin
        crc_r <= crc5_step(crc_r, sh_r[7]);
        sh_r  <= {sh_r[6:0], 1'b0};
        cnt_r <= cnt_r - 3'd1;
      end
      if (load_byte_s) begin
        sh_r  <= i_rx_byte;
        cnt_r <= 3'd7;
      end
      if (load_hb_s) begin
        sh_r      <= hb_r;
        cnt_r     <= 3'd7;
        hb_full_r <= 1'b0;
      end
      if (store_hb_s) begin
        hb_r      <= i_rx_byte;
        hb_full_r <= 1'b1;
      end
      if (drop_s) begin
        err_r <= 1'b1;
      end
      if (enter_done_s) begin
        value_r <= crc_r;
        valid_r <= 1'b1;
      end
      if (exit_done_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign o_rx_crc_value     = value_r;
  assign o_rx_crc_valid     = valid_r;
  assign o_crc_busy         = busy_s;
  assign o_ddrccc_crc_error = err_r;

endmodule

// File: tb/tb_rx_crc5_engine.sv
// Directed bench for rx_crc5_engine: expected CRCs queued at stimulus time,
// popped and compared when o_rx_crc_valid rises.
module tb_rx_crc5_engine;

  logic       clk;
  logic       rst_n;
  logic       crc_init;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       crc_en;
  logic [4:0] crc_value;
  logic       crc_valid;
  logic       crc_busy;
  logic       crc_error;

  int         chk_cnt;
  int         pass_cnt;
  int         fail_cnt;
  logic [4:0] exp_q[$];

  rx_crc5_engine dut (
    .i_sys_clk          (clk),
    .i_sys_rst          (rst_n),
    .i_ddrccc_crc_init  (crc_init),
    .i_rx_byte_valid    (byte_valid),
    .i_rx_byte          (rx_byte),
    .i_rx_crc_en        (crc_en),
    .o_rx_crc_value     (crc_value),
    .o_rx_crc_valid     (crc_valid),
    .o_crc_busy         (crc_busy),
    .o_ddrccc_crc_error (crc_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model_crc(input logic [4:0] seed, input logic [7:0] b);
    logic [4:0] c;
    c = seed;
    for (int i = 7; i >= 0; i--) begin
      if (c[4] ^ b[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_byte(input logic [7:0] b, input logic en);
    rx_byte    = b;
    byte_valid = 1'b1;
    crc_en     = en;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic do_init();
    crc_en   = 1'b0;
    crc_init = 1'b1;
    tick();
    crc_init = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound, input int exp_lat);
    int n;
    logic [4:0] exp;
    n = 0;
    while (!crc_valid && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(crc_valid), 32'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    exp = exp_q.pop_front();
    check({tag, "_value"}, 32'(crc_value), 32'(exp));
  endtask

  initial begin
    logic [4:0] m;
    logic [7:0] rb;
    int n;
    chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
    rst_n = 1'b0; crc_init = 1'b0; byte_valid = 1'b0; rx_byte = 8'h00; crc_en = 1'b0;
    repeat (3) tick();
    check("rst_value", 32'(crc_value), 32'd0);
    check("rst_valid", 32'(crc_valid), 32'd0);
    check("rst_busy",  32'(crc_busy),  32'd0);
    check("rst_error", 32'(crc_error), 32'd0);
    rst_n = 1'b1;
    tick();

    // single 0xFF with crc_en already high
    do_init();
    exp_q.push_back(5'b11011);
    pulse_byte(8'hFF, 1'b1);
    check("ff_busy", 32'(crc_busy), 32'd1);
    wait_valid("ff", 12, 9);
    pulse_byte(8'h12, 1'b1);
    check("done_byte_err", 32'(crc_error), 32'd1);
    check("done_hold_valid", 32'(crc_valid), 32'd1);
    check("done_hold_value", 32'(crc_value), 32'(5'b11011));
    crc_en = 1'b0;
    tick();
    check("done_exit_valid", 32'(crc_valid), 32'd0);
    check("err_sticky", 32'(crc_error), 32'd1);
    do_init();
    check("init_clr_err", 32'(crc_error), 32'd0);

    // two 0x00 bytes, second one on the last-bit cycle of the first
    pulse_byte(8'h00, 1'b0);
    repeat (7) tick();
    pulse_byte(8'h00, 1'b0);
    check("first_byte_crc", 32'(dut.crc_r), 32'(5'b01111));
    check("no_bubble_busy", 32'(crc_busy), 32'd1);
    crc_en = 1'b1;
    exp_q.push_back(5'b00001);
    wait_valid("zz_spaced", 20, 9);

    // second byte 3 clocks later lands in the holding buffer
    do_init();
    pulse_byte(8'h00, 1'b0);
    tick(); tick();
    pulse_byte(8'h00, 1'b0);
    check("hb_full", 32'(dut.hb_full_r), 32'd1);
    n = 0;
    while (crc_busy && n < 30) begin
      tick();
      n++;
    end
    check("busy_len", 32'(3 + n), 32'd16);
    crc_en = 1'b1;
    exp_q.push_back(5'b00001);
    wait_valid("zz_held", 5, 1);
    check("held_no_err", 32'(crc_error), 32'd0);

    // overrun: third byte dropped
    do_init();
    pulse_byte(8'hA5, 1'b0);
    pulse_byte(8'h3C, 1'b0);
    check("overrun_pre_err", 32'(crc_error), 32'd0);
    pulse_byte(8'hFF, 1'b0);
    check("overrun_err", 32'(crc_error), 32'd1);
    crc_en = 1'b1;
    exp_q.push_back(model_crc(model_crc(5'b11111, 8'hA5), 8'h3C));
    wait_valid("overrun", 30, -1);
    check("overrun_err_hold", 32'(crc_error), 32'd1);

    // crc_en raised mid-shift: valid waits for the fold to finish
    do_init();
    pulse_byte(8'hFF, 1'b0);
    tick(); tick();
    crc_en = 1'b1;
    exp_q.push_back(5'b11011);
    wait_valid("late_en", 12, 7);

    // four pseudo-random bytes back to back against the reference model
    do_init();
    m = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom_range(0, 255));
      m = model_crc(m, rb);
      pulse_byte(rb, 1'b0);
      repeat (7) tick();
    end
    crc_en = 1'b1;
    exp_q.push_back(m);
    wait_valid("rand4", 12, 2);

    // init colliding with a byte mid-shift
    do_init();
    pulse_byte(8'hA5, 1'b0);
    repeat (3) tick();
    rx_byte = 8'h77; byte_valid = 1'b1; crc_init = 1'b1;
    tick();
    byte_valid = 1'b0; crc_init = 1'b0;
    check("init_busy", 32'(crc_busy), 32'd0);
    check("init_crc", 32'(dut.crc_r), 32'(5'b11111));
    tick(); tick();
    check("init_discard_busy", 32'(crc_busy), 32'd0);
    exp_q.push_back(5'b11011);
    pulse_byte(8'hFF, 1'b1);
    wait_valid("post_init", 12, 9);

    // asynchronous reset mid-shift
    crc_en = 1'b0;
    tick();
    pulse_byte(8'h5A, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(crc_busy),  32'd0);
    check("arst_value", 32'(crc_value), 32'd0);
    check("arst_valid", 32'(crc_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(5'b11011);
    pulse_byte(8'hFF, 1'b1);
    wait_valid("post_arst", 12, 9);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
